// File: rtl/ahb_sram_slave.sv
// AHB-lite SRAM slave: single-cycle data phase, two-cycle ERROR, optional wait states.
// Optional feature macro: AHB_SLV_WAIT_EN (adds WAIT_CYC wait states to every legal transfer).
module ahb_sram_slave #(
    parameter int AW       = 12,
    parameter int DEPTH    = 1024,
    parameter int WAIT_CYC = 1
) (
    input  logic          hclk,
    input  logic          hreset,
    input  logic          hsel,
    input  logic [AW-1:0] haddr,
    input  logic [1:0]    htrans,
    input  logic          hwrite,
    input  logic [2:0]    hsize,
    input  logic [2:0]    hburst,
    input  logic [31:0]   hwdata,
    input  logic          hready,
    output logic [31:0]   hrdata,
    output logic          hreadyout,
    output logic          hresp
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t        state, state_n;
    logic [IW-1:0] a_word;
    logic [1:0]    a_lane;
    logic [1:0]    a_size;
    logic          a_write;
    logic [31:0]   mem [DEPTH];

    logic capture, legal, align_ok, range_ok, go_wait;
    logic [3:0] be;
    logic unused_ok;

    assign unused_ok = ^{hburst, htrans[0], WAIT_CYC[0]};

    // WAIT and ERR1 hold the bus, so no new address phase can be taken there.
    assign capture = hsel & hready & htrans[1] & hreadyout;

    always_comb begin
        align_ok = 1'b0;
        case (hsize)
            3'd0:    align_ok = 1'b1;
            3'd1:    align_ok = ~haddr[0];
            3'd2:    align_ok = (haddr[1:0] == 2'b00);
            default: align_ok = 1'b0;
        endcase
    end

    assign range_ok = ({1'b0, haddr} < (AW+1)'(DEPTH*4));
    assign legal    = align_ok & range_ok;

`ifdef AHB_SLV_WAIT_EN
    localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    logic [CW-1:0] wcnt;

    assign go_wait = (WAIT_CYC > 0);

    always_ff @(posedge hclk) begin
        if (hreset)
            wcnt <= '0;
        else if (state != S_WAIT && state_n == S_WAIT)
            wcnt <= CW'(WAIT_CYC - 1);
        else if (state == S_WAIT)
            wcnt <= wcnt - 1'b1;
    end
`else
    assign go_wait = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        hreadyout = 1'b1;
        hresp     = 1'b0;
        case (state)
`ifdef AHB_SLV_WAIT_EN
            S_WAIT: begin
                hreadyout = 1'b0;
                if (wcnt == '0) state_n = S_DATA;
            end
`endif
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                state_n   = S_ERR2;
            end
            default: begin
                hresp = (state == S_ERR2);
                if (capture)
                    state_n = !legal ? S_ERR1 : (go_wait ? S_WAIT : S_DATA);
                else
                    state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
            if (capture) begin
                a_word  <= haddr[IW+1:2];
                a_lane  <= haddr[1:0];
                a_size  <= hsize[1:0];
                a_write <= hwrite;
            end
        end
    end

    always_comb begin
        case (a_size)
            2'd0:    be = 4'b0001 << a_lane;
            2'd1:    be = 4'b0011 << a_lane;
            default: be = 4'b1111;
        endcase
    end

    // Write commits on the completing edge, so a read data phase right after sees it.
    always_ff @(posedge hclk) begin
        if (!hreset && state == S_DATA && a_write) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[a_word][8*b +: 8] <= hwdata[8*b +: 8];
        end
    end

    assign hrdata = (state == S_DATA) ? mem[a_word] : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: stimulus pushes expected responses, monitor pops and compares.
module tb_ahb_sram_slave;
    localparam int AW = 13, DEPTH = 1024, WAIT_CYC = 2;
`ifdef AHB_SLV_WAIT_EN
    localparam int WAITS = WAIT_CYC;
`else
    localparam int WAITS = 0;
`endif

    logic          hclk, hreset, hsel, hwrite, hready, hreadyout, hresp, bus_stall;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic [2:0]    hsize, hburst;
    logic [31:0]   hwdata, hrdata;

    assign hready = hreadyout & ~bus_stall;

    ahb_sram_slave #(.AW(AW), .DEPTH(DEPTH), .WAIT_CYC(WAIT_CYC)) dut (
        .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
        .hready(hready), .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    typedef struct { bit err; bit rd; logic [31:0] data; int waits; } exp_t;

    exp_t        sbq[$];
    logic [31:0] model [DEPTH];
    int          checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(input int a, input int sz);
        return (sz <= 2) && (a % (1 << sz) == 0) && (a < DEPTH*4);
    endfunction

    // One AHB transfer: address phase now, hwdata driven in the following data phase.
    task automatic xfer(input int a, input bit w, input int sz, input logic [31:0] wd,
                        input bit sel = 1'b1, input logic [1:0] tr = 2'b10);
        exp_t e;
        int   n;
        hsel = sel; haddr = AW'(a); htrans = tr; hwrite = w; hsize = 3'(sz);
        hburst = 3'($urandom_range(0, 7));
        n = 0;
        forever begin
            @(negedge hclk);
            if (hready) break;
            n++;
            if (n > 50) begin
                chk("addr_phase_timeout", 0, 1);
                break;
            end
        end
        if (sel && tr[1]) begin
            e.err   = !is_legal(a, sz);
            e.rd    = !w;
            e.waits = e.err ? 1 : WAITS;
            e.data  = model[(a / 4) % DEPTH];
            if (!e.err && w)
                for (int b = 0; b < (1 << sz); b++)
                    model[a / 4][8*((a % 4) + b) +: 8] = wd[8*((a % 4) + b) +: 8];
            sbq.push_back(e);
        end
        @(posedge hclk); #1;
        hwdata = wd;
        htrans = 2'b00;
    endtask

    // Monitor: tracks data phases from bus signals and compares against the queue.
    bit   dp = 1'b0;
    int   stalls = 0;
    exp_t me;

    always @(negedge hclk) begin
        if (hreset) begin
            dp = 1'b0;
            stalls = 0;
            sbq.delete();
        end else begin
            if (dp) begin
                if (sbq.size() == 0) begin
                    chk("scoreboard_empty", 0, 1);
                    dp = 1'b0;
                end else if (!hreadyout) begin
                    stalls++;
                    chk("stall_hresp", hresp, sbq[0].err);
                    if (stalls > 20) begin
                        chk("data_phase_timeout", stalls, sbq[0].waits);
                        void'(sbq.pop_front());
                        dp = 1'b0;
                        stalls = 0;
                    end
                end else begin
                    me = sbq.pop_front();
                    chk("hresp", hresp, me.err);
                    chk("stall_cycles", stalls, me.waits);
                    if (me.rd && !me.err) chk("hrdata", hrdata, me.data);
                    dp = 1'b0;
                    stalls = 0;
                end
            end else begin
                chk("idle_outputs", {hreadyout, hresp, hrdata}, {1'b1, 1'b0, 32'h0});
            end
            if (hsel && htrans[1] && hready) dp = 1'b1;
        end
    end

    initial begin
        int a, sz, n;
        hreset = 1'b1; bus_stall = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00;
        hwrite = 1'b0; hsize = 3'd2; hburst = 3'd0; hwdata = '0;

        repeat (2) begin
            @(negedge hclk);
            chk("reset_outputs", {hreadyout, hresp, hrdata}, {1'b1, 1'b0, 32'h0});
        end
        @(posedge hclk); #1;
        hreset = 1'b0;
        repeat (3) @(posedge hclk);
        #1;

        for (int i = 0; i < 16; i++) xfer(i*4, 1'b1, 2, $urandom());
        for (int i = DEPTH-4; i < DEPTH; i++) xfer(i*4, 1'b1, 2, $urandom());

        // Back-to-back word write then read of the same word
        xfer('h10, 1'b1, 2, 32'hDEADBEEF);
        xfer('h10, 1'b0, 2, 32'h0);

        // Byte and halfword lane merges
        xfer('h10, 1'b1, 2, 32'h11223344);
        xfer('h13, 1'b1, 0, 32'hAA000000);
        xfer('h10, 1'b0, 2, 32'h0);
        xfer('h12, 1'b1, 1, 32'h55660000);
        xfer('h10, 1'b0, 2, 32'h0);

        // Illegal accesses, then confirm memory untouched
        xfer('h02, 1'b0, 2, 32'h0);
        xfer('h00, 1'b0, 3, 32'h0);
        xfer('h1000, 1'b0, 2, 32'h0);
        xfer('h1000, 1'b1, 2, 32'hFFFFFFFF);
        xfer('h11, 1'b1, 1, 32'hFFFFFFFF);
        xfer('h0E, 1'b1, 2, 32'hFFFFFFFF);
        xfer('h10, 1'b0, 2, 32'h0);
        xfer('h0C, 1'b0, 2, 32'h0);

        // Bus stalled by another slave during address phase: nothing captured
        hsel = 1'b1; haddr = AW'('h10); htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2;
        bus_stall = 1'b1;
        @(posedge hclk); #1;
        bus_stall = 1'b0; htrans = 2'b00;
        @(posedge hclk); #1;

        // Reset in the data phase of a write drops the write
        hsel = 1'b1; haddr = AW'('h20); htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        n = 0;
        forever begin
            @(negedge hclk);
            if (hready || n > 50) break;
            n++;
        end
        @(posedge hclk); #1;
        hwdata = 32'hBAD0BAD0; htrans = 2'b00; hreset = 1'b1;
        @(posedge hclk); #1;
        hreset = 1'b0;
        @(negedge hclk);
        chk("after_mid_reset", {hreadyout, hresp}, {1'b1, 1'b0});
        @(posedge hclk); #1;
        xfer('h20, 1'b0, 2, 32'h0);

        // Randomized mix of sizes, alignments, ranges, selects and trans types
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0:       a = 'h1000 + int'($urandom_range(0, 'hFFF));
                1, 2:    a = (DEPTH-4)*4 + int'($urandom_range(0, 15));
                default: a = int'($urandom_range(0, 63));
            endcase
            sz = ($urandom_range(0, 9) == 0) ? int'($urandom_range(3, 7)) : int'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) a = a & ~((1 << (sz > 2 ? 2 : sz)) - 1);
            xfer(a, 1'($urandom_range(0, 1)), sz, $urandom(),
                 1'($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3)));
            if ($urandom_range(0, 7) == 0) begin
                @(posedge hclk); #1;
            end
        end

        hsel = 1'b0; htrans = 2'b00;
        n = 0;
        while ((sbq.size() != 0 || dp) && n < 60) begin
            @(posedge hclk);
            n++;
        end
        chk("drain_pending", sbq.size(), 0);
        repeat (2) @(posedge hclk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
